// File: rtl/block_dispatcher_pkg.sv
// Block dispatcher shared definitions.
// State codes, default sizing and pointer width helper.
package block_dispatcher_pkg;

  localparam int DEF_NUM_PROC    = 4;
  localparam int DEF_INDEX_WIDTH = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DISPATCH = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WAIT_ALL = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  function automatic int ptr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_dispatcher_rr.sv
// Round-robin picker: first set mask bit strictly
// after the pointer, wrapping to bit 0.
module rr_picker
  import block_dispatcher_pkg::*;
#(
  parameter int n  = DEF_NUM_PROC,
  parameter int pw = 2
) (
  input  logic [n-1:0]  mask,
  input  logic [pw-1:0] ptr,
  output logic [n-1:0]  grant,
  output logic          valid
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!found && mask[k] && k > int'(ptr)) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int k = 0; k < n; k++) begin
      if (!found && mask[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |mask;

endmodule

// File: rtl/block_dispatcher.sv
// Hands out C_ij block indices row-major to free
// processors and counts completed blocks.
module block_dispatcher
  import block_dispatcher_pkg::*;
#(
  parameter int num_proc    = DEF_NUM_PROC,
  parameter int index_width = DEF_INDEX_WIDTH
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic                     in_start,
  input  logic [index_width-1:0]   in_mu,
  input  logic [num_proc-1:0]      in_index_ack,
  input  logic [num_proc-1:0]      in_result_ready,
  output logic [index_width-1:0]   out_row_index,
  output logic [index_width-1:0]   out_col_index,
  output logic [num_proc-1:0]      out_index_ready,
  output logic                     out_busy,
  output logic                     out_done,
  output logic [2*index_width-1:0] out_block_count
);

  localparam int PW = ptr_w(num_proc);
  localparam int CW = 2 * index_width;

  logic [2:0]             state;
  logic [index_width-1:0] mu_q;
  logic [index_width-1:0] row_q;
  logic [index_width-1:0] col_q;
  logic [num_proc-1:0]    free_q;
  logic [num_proc-1:0]    sel_q;
  logic [num_proc-1:0]    grant;
  logic [num_proc-1:0]    ack_hit;
  logic [num_proc-1:0]    rel;
  logic [PW-1:0]          ptr_q;
  logic [PW-1:0]          grant_idx;
  logic                   grant_valid;
  logic                   last_col;
  logic                   last_row;
  logic [CW-1:0]          count_q;

  rr_picker #(
    .n  (num_proc),
    .pw (PW)
  ) u_pick (
    .mask  (free_q),
    .ptr   (ptr_q),
    .grant (grant),
    .valid (grant_valid)
  );

  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < num_proc; k++) begin
      if (grant[k]) grant_idx = PW'(k);
    end
  end

  // only the selected processor's ack counts
  assign ack_hit  = (state == S_ISSUE) ?
                    (in_index_ack & sel_q) : '0;
  // results from already-free processors are dropped
  assign rel      = ~free_q & in_result_ready;
  assign last_col = col_q == mu_q - 1'b1;
  assign last_row = row_q == mu_q - 1'b1;

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state   <= S_IDLE;
      mu_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      free_q  <= '1;
      sel_q   <= '0;
      ptr_q   <= PW'(num_proc - 1);
      count_q <= '0;
    end else begin
      free_q  <= (free_q & ~ack_hit) | rel;
      count_q <= count_q + CW'($countones(rel));
      unique case (state)
        S_IDLE: begin
          if (in_start) begin
            mu_q    <= in_mu;
            count_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            state   <= (in_mu == '0) ?
                       S_DONE : S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (grant_valid) begin
            sel_q <= grant;
            ptr_q <= grant_idx;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (|ack_hit) begin
            sel_q <= '0;
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                row_q <= '0;
                state <= S_WAIT_ALL;
              end else begin
                row_q <= row_q + 1'b1;
                state <= S_DISPATCH;
              end
            end else begin
              col_q <= col_q + 1'b1;
              state <= S_DISPATCH;
            end
          end
        end
        S_WAIT_ALL: begin
          if (&free_q) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_row_index   = row_q;
  assign out_col_index   = col_q;
  assign out_index_ready = (state == S_ISSUE) ? sel_q : '0;
  assign out_busy        = state != S_IDLE;
  assign out_done        = state == S_DONE;
  assign out_block_count = count_q;

endmodule

// File: tb/tb_block_dispatcher.sv
// Bench for block_dispatcher: processor responder,
// queue scoreboard and round-robin reference.
module tb_block_dispatcher;

  localparam int NP = 4;
  localparam int IW = 4;

  typedef struct packed {
    logic [IW-1:0] i;
    logic [IW-1:0] j;
  } blk_t;

  logic            in_clk = 1'b0;
  logic            in_reset = 1'b1;
  logic            in_start = 1'b0;
  logic [IW-1:0]   in_mu = '0;
  logic [NP-1:0]   in_index_ack = '0;
  logic [NP-1:0]   in_result_ready = '0;
  logic [IW-1:0]   out_row_index;
  logic [IW-1:0]   out_col_index;
  logic [NP-1:0]   out_index_ready;
  logic            out_busy;
  logic            out_done;
  logic [2*IW-1:0] out_block_count;

  block_dispatcher #(
    .num_proc    (NP),
    .index_width (IW)
  ) dut (
    .in_clk          (in_clk),
    .in_reset        (in_reset),
    .in_start        (in_start),
    .in_mu           (in_mu),
    .in_index_ack    (in_index_ack),
    .in_result_ready (in_result_ready),
    .out_row_index   (out_row_index),
    .out_col_index   (out_col_index),
    .out_index_ready (out_index_ready),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_block_count (out_block_count)
  );

  initial forever #5 in_clk = ~in_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  blk_t exp_q[$];
  int   exp_done_q[$];

  // responder configuration, set by the main sequence
  bit   hold = 1'b1;
  bit   hold_rr = 1'b0;
  bit   spur_en = 1'b0;
  bit   ack_rand = 1'b0;
  bit   rate_chk = 1'b0;
  bit   slow_en = 1'b0;
  int   ack_base = 0;
  int   slow_delay = 0;
  blk_t slow_blk = '0;
  int   res_lo = 5;
  int   res_hi = 5;
  int   res_len = 1;

  // responder / monitor state
  bit   busy_b[NP];
  int   free_edge[NP];
  int   res_at[NP];
  int   hold_left[NP];
  int   last_p;
  int   cur_p;
  int   cur_delay;
  int   held;
  int   last_issue_cyc;
  bit   acked_last;
  blk_t cur;
  logic [NP-1:0] prev_ir;

  initial forever begin
    @(posedge in_clk);
    cyc++;
  end

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic tick;
    @(posedge in_clk);
    #1;
  endtask

  // monitor + processor responder
  initial begin
    logic [NP-1:0] ir, ack, rr, spur, busy_vec;
    int exp_p;
    forever begin
      @(negedge in_clk);
      ir = out_index_ready;
      if (hold) begin
        for (int p = 0; p < NP; p++) begin
          busy_b[p] = 1'b0;
          free_edge[p] = 0;
          res_at[p] = 0;
          hold_left[p] = 0;
        end
        last_p = NP - 1;
        prev_ir = '0;
        acked_last = 1'b0;
        held = 0;
        cur = '0;
        last_issue_cyc = -1;
        in_index_ack = '0;
        in_result_ready = hold_rr ? '1 : '0;
      end else begin
        if (acked_last) check("strobe_drop", int'(ir), 0);
        acked_last = 1'b0;
        if (ir != '0 && prev_ir == '0) begin
          check("issue_onehot", int'($onehot(ir)), 1);
          cur_p = 0;
          for (int p = 0; p < NP; p++)
            if (ir[p]) cur_p = p;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got strobe %b, required none",
                     ir);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
            check("row_index", int'(out_row_index), int'(cur.i));
            check("col_index", int'(out_col_index), int'(cur.j));
          end
          exp_p = -1;
          for (int s = 1; s <= NP; s++) begin
            int p;
            p = (last_p + s) % NP;
            if (exp_p < 0 && !busy_b[p] && free_edge[p] <= cyc - 1)
              exp_p = p;
          end
          check("rr_proc", cur_p, exp_p);
          if (rate_chk && cur != '0)
            check("issue_gap", cyc - last_issue_cyc, 2);
          last_issue_cyc = cyc;
          last_p = cur_p;
          held = 0;
          if (slow_en && cur == slow_blk) cur_delay = slow_delay;
          else if (ack_rand) cur_delay = int'($urandom_range(ack_base, 0));
          else cur_delay = ack_base;
        end else if (ir != '0) begin
          check("strobe_stable", int'(ir), int'(prev_ir));
          check("row_stable", int'(out_row_index), int'(cur.i));
          check("col_stable", int'(out_col_index), int'(cur.j));
          held++;
        end
        if (out_done) begin
          if (exp_done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: got done=1, required 0");
          end else begin
            check("block_count", int'(out_block_count),
                  exp_done_q.pop_front());
          end
          check("blocks_left", exp_q.size(), 0);
        end
        busy_vec = '0;
        for (int p = 0; p < NP; p++) busy_vec[p] = busy_b[p];
        spur = spur_en ? (NP'($urandom) & ~busy_vec) : '0;
        ack = '0;
        rr = '0;
        if (ir != '0 && held == cur_delay) begin
          ack = ir;
          busy_b[cur_p] = 1'b1;
          res_at[cur_p] = cyc + int'($urandom_range(res_hi, res_lo));
          acked_last = 1'b1;
        end
        if (spur_en) ack = ack | (NP'($urandom) & ~ir);
        for (int p = 0; p < NP; p++) begin
          if (busy_b[p] && cyc >= res_at[p]) begin
            busy_b[p] = 1'b0;
            free_edge[p] = cyc + 1;
            hold_left[p] = res_len;
          end
          if (hold_left[p] > 0) begin
            rr[p] = 1'b1;
            hold_left[p]--;
          end
        end
        in_index_ack = ack;
        in_result_ready = rr | spur;
        prev_ir = ir;
      end
    end
  end

  task automatic do_reset;
    hold = 1'b1;
    in_reset = 1'b1;
    in_start = 1'b0;
    tick;
    in_reset = 1'b0;
    check("rst_index_ready", int'(out_index_ready), 0);
    check("rst_busy", int'(out_busy), 0);
    check("rst_done", int'(out_done), 0);
    check("rst_row", int'(out_row_index), 0);
    check("rst_col", int'(out_col_index), 0);
    check("rst_count", int'(out_block_count), 0);
    hold_rr = 1'b1;
    tick;
    tick;
    check("stale_result_count", int'(out_block_count), 0);
    check("stale_result_busy", int'(out_busy), 0);
    hold_rr = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    tick;
    hold = 1'b0;
  endtask

  task automatic start_job(int mu);
    for (int i = 0; i < mu; i++)
      for (int j = 0; j < mu; j++)
        exp_q.push_back('{i: IW'(i), j: IW'(j)});
    exp_done_q.push_back(mu * mu);
    in_mu = IW'(mu);
    in_start = 1'b1;
    tick;
    in_start = 1'b0;
    in_mu = IW'($urandom);
    check("busy_after_start", int'(out_busy), 1);
  endtask

  task automatic wait_job(int mu, int max_cyc, output int n);
    n = 0;
    while (!out_done && n < max_cyc) begin
      in_start = spur_en ? 1'($urandom) : 1'b0;
      tick;
      n++;
    end
    in_start = 1'b0;
    if (!out_done) begin
      checks++;
      errors++;
      $display("FAIL job_timeout: got no done in %0d cycles, required done (mu=%0d)",
               max_cyc, mu);
      do_reset;
    end else begin
      check("count_at_done", int'(out_block_count), mu * mu);
      tick;
      check("done_one_cycle", int'(out_done), 0);
      check("busy_after_done", int'(out_busy), 0);
      tick;
      check("count_held", int'(out_block_count), mu * mu);
    end
  endtask

  task automatic run_job(int mu, int max_cyc, output int n);
    start_job(mu);
    wait_job(mu, max_cyc, n);
  endtask

  initial begin
    int n;
    tick;
    do_reset;

    // all free, immediate acks: procs 0..3, one issue per 2 cycles
    ack_base = 0;
    res_lo = 5;
    res_hi = 5;
    rate_chk = 1'b1;
    run_job(2, 200, n);
    rate_chk = 1'b0;

    // empty job
    run_job(0, 200, n);
    check("mu0_done_latency", (n <= 1) ? 1 : 0, 1);

    // one slow ack on block (1,2)
    slow_en = 1'b1;
    slow_blk = '{i: IW'(1), j: IW'(2)};
    slow_delay = 7;
    res_lo = 3;
    res_hi = 3;
    run_job(3, 400, n);
    slow_en = 1'b0;

    // long result latency: processors saturate
    res_lo = 20;
    res_hi = 20;
    run_job(3, 600, n);

    // level-held results count once
    res_len = 10;
    run_job(2, 400, n);
    repeat (12) tick;
    res_len = 1;

    // reset in the middle of a job, then a fresh job
    res_lo = 5;
    res_hi = 5;
    start_job(4);
    n = 0;
    while (out_index_ready == '0 && n < 50) begin
      tick;
      n++;
    end
    check("reached_issue", (out_index_ready != '0) ? 1 : 0, 1);
    do_reset;
    run_job(1, 200, n);

    // randomized jobs with spurious acks, results and starts
    spur_en = 1'b1;
    ack_rand = 1'b1;
    ack_base = 3;
    res_lo = 1;
    res_hi = 12;
    for (int t = 0; t < 12; t++) begin
      run_job(int'($urandom_range(5, 0)), 3000, n);
    end
    spur_en = 1'b0;
    repeat (3) tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 50000 cycles, required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/block_dispatcher.md
BLOCK_DISPATCHER -- requirements
Module: block_dispatcher

Interface
REQ-001 SHALL have parameter num_proc, default 4: number of attached processors (1..8).
REQ-002 SHALL have parameter index_width, default 4: width of block row/column index and mu.
REQ-003 SHALL have port in_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port in_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_start  input  1  begin a job; sampled only in IDLE.
REQ-006 SHALL have port in_mu  input  index_width  blocks per matrix dimension; latched on accepted start.
REQ-007 SHALL have port in_index_ack  input  num_proc  per-processor acknowledge of issued indices.
REQ-008 SHALL have port in_result_ready  input  num_proc  per-processor block C_ij finished (level or pulse).
REQ-009 SHALL have port out_row_index  output  index_width  shared row index i.
REQ-010 SHALL have port out_col_index  output  index_width  shared column index j.
REQ-011 SHALL have port out_index_ready  output  num_proc  one-hot (or zero) indices-valid strobe.
REQ-012 SHALL have port out_busy  output  1  job in progress.
REQ-013 SHALL have port out_done  output  1  one-cycle job-complete pulse.
REQ-014 SHALL have port out_block_count  output  2*index_width  blocks completed in current/last job.

Function
REQ-015 SHALL implement FSM states IDLE, DISPATCH, ISSUE, WAIT_ALL, DONE.
REQ-016 IDLE: in_start=1 -> latch mu, clear count and i=j=0, busy=1, go DISPATCH; if mu=0 go DONE directly.
REQ-017 SHALL keep free mask, one bit per processor; bit cleared on ack, set on in_result_ready while cleared.
REQ-018 in_result_ready from an already-free processor SHALL be ignored (no count, no state change).
REQ-019 Each free-transition via result_ready SHALL increment out_block_count by 1, independent of FSM state.
REQ-020 DISPATCH: if any free processor, SHALL select one round-robin (search starts after last-issued index, wrapping) and go ISSUE next cycle; else remain.
REQ-021 ISSUE: out_index_ready SHALL be high on selected bit only; out_row_index/out_col_index SHALL hold i/j stable until ack.
REQ-022 ISSUE: in_index_ack on selected bit sampled high -> strobe drops next cycle; acks on other bits ignored.
REQ-023 After ack, indices SHALL advance row-major: j+1; j=mu-1 wraps to 0 with i+1.
REQ-024 After ack of block (mu-1,mu-1) SHALL go WAIT_ALL; otherwise DISPATCH.
REQ-025 WAIT_ALL: when free mask all ones -> DONE.
REQ-026 DONE: out_done=1 one cycle, busy=0 from next cycle, go IDLE; out_block_count held until next start.
REQ-027 Simultaneous ack and result_ready on different processors SHALL both take effect same edge.
REQ-028 Result_ready on the selected processor while in ISSUE SHALL not cancel the issue.
REQ-029 in_start outside IDLE SHALL be ignored; in_mu changes mid-job SHALL be ignored.
REQ-030 Minimum issue rate: one block per 2 cycles given immediate acks.

Reset
REQ-031 in_reset=1 at a rising edge SHALL force IDLE, free mask all ones, i=j=0, round-robin pointer num_proc-1, count 0.
REQ-032 During/after reset: out_index_ready=0, out_busy=0, out_done=0, out_row_index=0, out_col_index=0.
REQ-033 Reset mid-job SHALL abandon the job with no out_done pulse; in-flight processor results thereafter ignored.

Structure
REQ-034 Shared package SHALL hold state encodings and default num_proc/index_width constants.
REQ-035 Round-robin free-processor picker SHALL be one sub-module, rr_picker (mask + pointer -> one-hot grant, valid).

Verification
REQ-036 mu=2, num_proc=4, acks same cycle, results 5 cycles later -> issues (0,0),(0,1),(1,0),(1,1) to procs 0,1,2,3; done, count=4.
REQ-037 mu=3, num_proc=2, results delayed 20 cycles -> never more than 2 outstanding; 9 issues row-major; count=9.
REQ-038 mu=0, start -> done pulse within 2 cycles, count=0, no index_ready.
REQ-039 Ack delayed 7 cycles with indices (1,2) -> index_ready and indices stable all 7 cycles.
REQ-040 Reset asserted in ISSUE during mu=4 job -> next cycle all outputs 0, IDLE; fresh start mu=1 completes count=1.
REQ-041 Level-held result_ready for 10 cycles on proc 1 -> count increments once.
